// File: rtl/comm_pkg.sv
// comm_pkg
// Shared constants and types for the commutator output side. The default
// channel count and data width must stay in step with the commutator that
// feeds comm_out_fifo.
//   COMM_N_OUT : number of commutator output channels
//   COMM_WD    : data width per channel
//   COMM_DEPTH : default entries per channel FIFO (power of 2, >= 2)
//   COMM_WCNT  : default width of the per-channel drop counter
//   data_t     : one channel data word
package comm_pkg;

  localparam int COMM_N_OUT = 13;
  localparam int COMM_WD    = 25;
  localparam int COMM_DEPTH = 8;
  localparam int COMM_WCNT  = 8;

  typedef logic [COMM_WD-1:0] data_t;

endpackage

// File: rtl/comm_chan_fifo.sv
// comm_chan_fifo
// Single-channel elastic FIFO. Accepts one-cycle write strobes that cannot
// be back-pressured and presents the head entry over valid/ready with
// first-word-fall-through data. Writes that arrive while the FIFO is full
// and not popping are dropped, and they are counted in a sticky flag and a
// saturating counter.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   req, data_in         : write strobe and write data
//   ready                : endpoint accepts the head entry
//   valid, data_out      : head entry available / head entry (0 when invalid)
//   ovf_flag, ovf_cnt    : sticky drop flag, saturating drop count
//   ovf_clr              : clears ovf_flag and ovf_cnt (wins over a drop)
module comm_chan_fifo
  import comm_pkg::*;
#(
  parameter int wD    = COMM_WD,
  parameter int DEPTH = COMM_DEPTH,
  parameter int wCNT  = COMM_WCNT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic [wD-1:0]   data_in,
  input  logic            ready,
  output logic            valid,
  output logic [wD-1:0]   data_out,
  output logic            ovf_flag,
  output logic [wCNT-1:0] ovf_cnt,
  input  logic            ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [wD-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q, valid_d;
  logic            ovf_flag_q, ovf_flag_d;
  logic [wCNT-1:0] ovf_cnt_q, ovf_cnt_d;
  logic            full, pop, push, drop;

  always_comb begin
    full = (count_q == FULL_CNT);
    pop  = valid_q & ready;
    push = req & (~full | pop);
    drop = req & full & ~pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_flag_d = ovf_flag_q;
    ovf_cnt_d  = ovf_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // An entry written into an empty FIFO becomes visible one cycle after
    // it lands (no bypass); a pop that empties the FIFO hides valid at once.
    valid_d = (count_q != '0) && (count_d != '0);

    if (ovf_clr) begin
      ovf_flag_d = 1'b0;
      ovf_cnt_d  = '0;
    end else if (drop) begin
      ovf_flag_d = 1'b1;
      if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + wCNT'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      ovf_flag_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      ovf_flag_q <= ovf_flag_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  // Storage carries no reset; pointers and occupancy define what is live.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= data_in;
  end

  // The head slot is only rewritten when the FIFO is empty or popping, so
  // data_out holds steady while valid is high and ready is low.
  assign valid    = valid_q;
  assign data_out = valid_q ? mem_q[rd_ptr_q] : '0;
  assign ovf_flag = ovf_flag_q;
  assign ovf_cnt  = ovf_cnt_q;

endmodule

// File: rtl/comm_out_fifo.sv
// comm_out_fifo
// Per-endpoint elastic buffer downstream of the pipelined commutator. Each
// of the nOUT channels gets its own independent comm_chan_fifo; this level
// only slices the packed buses.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_in, data_in       : per-channel write strobes and packed write data
//   valid_out, ready_in   : per-channel valid/ready handshake to endpoints
//   data_out              : packed head entries (channel k at [k*wD +: wD])
//   ovf_flag, ovf_cnt     : per-channel sticky drop flag and drop count
//   ovf_clr               : clears all drop flags and counts
module comm_out_fifo
  import comm_pkg::*;
#(
  parameter int nOUT  = COMM_N_OUT,
  parameter int wD    = COMM_WD,
  parameter int DEPTH = COMM_DEPTH,
  parameter int wCNT  = COMM_WCNT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [nOUT-1:0]      req_in,
  input  logic [nOUT*wD-1:0]   data_in,
  output logic [nOUT-1:0]      valid_out,
  input  logic [nOUT-1:0]      ready_in,
  output logic [nOUT*wD-1:0]   data_out,
  output logic [nOUT-1:0]      ovf_flag,
  output logic [nOUT*wCNT-1:0] ovf_cnt,
  input  logic                 ovf_clr
);

  for (genvar k = 0; k < nOUT; k++) begin : g_chan
    comm_chan_fifo #(
      .wD    (wD),
      .DEPTH (DEPTH),
      .wCNT  (wCNT)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .req      (req_in[k]),
      .data_in  (data_in[k*wD +: wD]),
      .ready    (ready_in[k]),
      .valid    (valid_out[k]),
      .data_out (data_out[k*wD +: wD]),
      .ovf_flag (ovf_flag[k]),
      .ovf_cnt  (ovf_cnt[k*wCNT +: wCNT]),
      .ovf_clr  (ovf_clr)
    );
  end

endmodule

// File: tb/tb_comm_out_fifo.sv
// tb_comm_out_fifo
// Self-checking bench for comm_out_fifo. A queue-per-channel model tracks
// what each endpoint must see; a negedge process compares every channel on
// every cycle, and directed sequences add literal expectations.
module tb_comm_out_fifo;

  localparam int nOUT  = 13;
  localparam int wD    = 25;
  localparam int DEPTH = 8;
  localparam int wCNT  = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [nOUT-1:0]      req_in;
  logic [nOUT*wD-1:0]   data_in;
  logic [nOUT-1:0]      valid_out;
  logic [nOUT-1:0]      ready_in;
  logic [nOUT*wD-1:0]   data_out;
  logic [nOUT-1:0]      ovf_flag;
  logic [nOUT*wCNT-1:0] ovf_cnt;
  logic                 ovf_clr;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  // Model: the entries each endpoint is still owed, in order.
  logic [wD-1:0] model_q [nOUT][$];
  bit            model_hidden [nOUT];
  bit            model_flag [nOUT];
  int            model_cnt [nOUT];

  always #5 clk = ~clk;

  comm_out_fifo #(
    .nOUT  (nOUT),
    .wD    (wD),
    .DEPTH (DEPTH),
    .wCNT  (wCNT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_in    (req_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .ovf_flag  (ovf_flag),
    .ovf_cnt   (ovf_cnt),
    .ovf_clr   (ovf_clr)
  );

  task automatic check_output(input string name, input int ch,
                              input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s ch%0d actual=0x%0h expected=0x%0h at %0t",
               name, ch, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [nOUT-1:0] req, input logic [nOUT-1:0] rdy,
                                input logic clr, input logic rst, input logic [wD-1:0] val);
    req_in   = req;
    ready_in = rdy;
    ovf_clr  = clr;
    reset    = rst;
    data_in  = {nOUT{val}};
    step();
  endtask

  // Model update: apply the handshake rules to the inputs seen at the edge.
  always @(posedge clk) begin
    for (int k = 0; k < nOUT; k++) begin
      if (reset) begin
        model_q[k].delete();
        model_hidden[k] = 1'b0;
        model_flag[k]   = 1'b0;
        model_cnt[k]    = 0;
      end else begin
        automatic int sz      = model_q[k].size();
        automatic bit visible = (sz > 0) && !model_hidden[k];
        automatic bit do_pop  = visible && ready_in[k];
        automatic bit do_push = req_in[k] && ((sz < DEPTH) || do_pop);
        automatic bit do_drop = req_in[k] && !do_push;
        if (do_pop) void'(model_q[k].pop_front());
        if (do_push) model_q[k].push_back(data_in[k*wD +: wD]);
        model_hidden[k] = do_push && (sz == 0);
        if (ovf_clr) begin
          model_flag[k] = 1'b0;
          model_cnt[k]  = 0;
        end else if (do_drop) begin
          model_flag[k] = 1'b1;
          model_cnt[k]  = (model_cnt[k] >= 255) ? 255 : model_cnt[k] + 1;
        end
      end
    end
  end

  // Compare process: every channel, every cycle once reset has been applied.
  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < nOUT; k++) begin
        automatic bit            exp_valid = (model_q[k].size() > 0) && !model_hidden[k];
        automatic logic [wD-1:0] exp_data  = exp_valid ? model_q[k][0] : '0;
        check_output("valid_out", k, 64'(valid_out[k]), 64'(exp_valid));
        check_output("data_out", k, 64'(data_out[k*wD +: wD]), 64'(exp_data));
        check_output("ovf_flag", k, 64'(ovf_flag[k]), 64'(model_flag[k]));
        check_output("ovf_cnt", k, 64'(ovf_cnt[k*wCNT +: wCNT]), 64'(model_cnt[k]));
      end
    end
  end

  initial begin
    req_in   = '0;
    ready_in = '0;
    ovf_clr  = 1'b0;
    reset    = 1'b1;
    data_in  = '0;

    // Reset, with writes active that must be ignored.
    @(negedge clk);
    apply_stimulus('1, '1, 1'b0, 1'b1, 25'h1555555);
    check_en = 1'b1;
    apply_stimulus('1, '0, 1'b0, 1'b1, 25'h0AAAAAA);
    check_output("reset_valid", -1, 64'(valid_out), 64'(0));
    check_output("reset_data", -1, 64'(data_out[63:0]), 64'(0));
    check_output("reset_flag", -1, 64'(ovf_flag), 64'(0));
    check_output("reset_cnt", -1, 64'(ovf_cnt[63:0]), 64'(0));

    $display("[TB] single write");
    apply_stimulus(13'h0008, '0, 1'b0, 1'b0, 25'h0ABCDEF);
    check_output("single_latency", 3, 64'(valid_out), 64'(0));
    apply_stimulus('0, '0, 1'b0, 1'b0, '0);
    check_output("single_valid", 3, 64'(valid_out), 64'(13'h0008));
    check_output("single_data", 3, 64'(data_out[3*wD +: wD]), 64'(25'h0ABCDEF));
    apply_stimulus('0, 13'h0008, 1'b0, 1'b0, '0);
    check_output("single_pop", 3, 64'(valid_out), 64'(0));

    $display("[TB] fill and drop");
    for (int i = 1; i <= 10; i++) apply_stimulus(13'h0001, '0, 1'b0, 1'b0, wD'(i));
    check_output("fill_flag", 0, 64'(ovf_flag[0]), 64'(1));
    check_output("fill_cnt", 0, 64'(ovf_cnt[0 +: wCNT]), 64'(2));
    for (int i = 1; i <= 8; i++) begin
      check_output("fill_order", 0, 64'(data_out[0 +: wD]), 64'(i));
      apply_stimulus('0, 13'h0001, 1'b0, 1'b0, '0);
    end
    check_output("fill_empty", 0, 64'(valid_out[0]), 64'(0));
    apply_stimulus('0, '0, 1'b1, 1'b0, '0);
    check_output("fill_clr", 0, 64'(ovf_flag[0]), 64'(0));

    $display("[TB] full with simultaneous pop");
    for (int i = 1; i <= 8; i++) apply_stimulus(13'h0002, '0, 1'b0, 1'b0, wD'(i));
    apply_stimulus(13'h0002, 13'h0002, 1'b0, 1'b0, wD'(9));
    check_output("fullpop_flag", 1, 64'(ovf_flag[1]), 64'(0));
    apply_stimulus(13'h0002, '0, 1'b0, 1'b0, wD'(10));
    check_output("fullpop_still_full", 1, 64'(ovf_cnt[1*wCNT +: wCNT]), 64'(1));
    for (int i = 2; i <= 9; i++) begin
      check_output("fullpop_order", 1, 64'(data_out[1*wD +: wD]), 64'(i));
      apply_stimulus('0, 13'h0002, 1'b0, 1'b0, '0);
    end
    check_output("fullpop_empty", 1, 64'(valid_out[1]), 64'(0));
    apply_stimulus('0, '0, 1'b1, 1'b0, '0);

    $display("[TB] all channels with random backpressure");
    for (int c = 0; c < 100; c++) begin
      req_in   = '1;
      ready_in = nOUT'($urandom);
      ovf_clr  = 1'b0;
      reset    = 1'b0;
      for (int k = 0; k < nOUT; k++) data_in[k*wD +: wD] = wD'($urandom);
      step();
    end
    for (int c = 0; c < 12; c++) apply_stimulus('0, '1, 1'b0, 1'b0, '0);
    check_output("random_drained", -1, 64'(valid_out), 64'(0));
    apply_stimulus('0, '0, 1'b1, 1'b0, '0);

    $display("[TB] saturation and clear");
    for (int i = 0; i < 308; i++) apply_stimulus(13'h1000, '0, 1'b0, 1'b0, wD'(i));
    check_output("sat_cnt", 12, 64'(ovf_cnt[12*wCNT +: wCNT]), 64'(255));
    check_output("sat_flag", 12, 64'(ovf_flag[12]), 64'(1));
    apply_stimulus(13'h1000, '0, 1'b1, 1'b0, 25'h1FFFFFF);
    check_output("clr_flag", 12, 64'(ovf_flag[12]), 64'(0));
    check_output("clr_cnt", 12, 64'(ovf_cnt[12*wCNT +: wCNT]), 64'(0));
    for (int c = 0; c < 9; c++) apply_stimulus('0, 13'h1000, 1'b0, 1'b0, '0);

    $display("[TB] mid-operation reset");
    for (int c = 0; c < 3; c++) apply_stimulus('1, 13'h0055, 1'b0, 1'b0, wD'(c + 100));
    apply_stimulus('1, '0, 1'b0, 1'b1, 25'h0777777);
    check_output("mid_reset_valid", -1, 64'(valid_out), 64'(0));
    check_output("mid_reset_data", -1, 64'(data_out[63:0]), 64'(0));
    apply_stimulus(13'h0020, '0, 1'b0, 1'b0, 25'h1234567);
    check_output("post_reset_latency", 5, 64'(valid_out), 64'(0));
    apply_stimulus('0, '0, 1'b0, 1'b0, '0);
    check_output("post_reset_valid", 5, 64'(valid_out), 64'(13'h0020));
    check_output("post_reset_data", 5, 64'(data_out[5*wD +: wD]), 64'(25'h1234567));
    apply_stimulus('0, '1, 1'b0, 1'b0, '0);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/comm_out_fifo.md
# comm_out_fifo

Per-endpoint elastic buffer placed directly downstream of the pipelined commutator. Absorbs the commutator's single-cycle, non-backpressurable `req`/`data` pulses on each of `nOUT` output channels into independent FIFOs. Presents each channel to its endpoint over a valid/ready handshake. Drops on overflow are counted and flagged per channel.

## Interface
- `nOUT`, 13: number of output channels; must match the commutator's `nOUT`.
- `wD`, 25: data width per channel.
- `DEPTH`, 8: entries per channel FIFO; power of 2, ≥2.
- `wCNT`, 8: width of the per-channel saturating drop counter.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `req_in`, in, `nOUT`: per-channel write strobe from the commutator; one-cycle pulses, possibly back-to-back.
- `data_in`, in, `nOUT*wD`: channel k occupies `[(k+1)*wD-1:k*wD]`; sampled only when `req_in[k]` is high.
- `valid_out`, out, `nOUT`: channel k head entry is available.
- `ready_in`, in, `nOUT`: endpoint k accepts the head entry.
- `data_out`, out, `nOUT*wD`: head entry per channel, same packing as `data_in`.
- `ovf_flag`, out, `nOUT`: sticky; set when channel k drops a write.
- `ovf_cnt`, out, `nOUT*wCNT`: per-channel drop count, saturating at `2^wCNT-1`.
- `ovf_clr`, in, 1: clears all `ovf_flag` and `ovf_cnt`.

## Operation
- Channels are fully independent; there is no shared arbitration.
- **Push:** `req_in[k]` is high and the FIFO is not full, or it is full and a pop occurs in the same cycle.
- **Pop:** `valid_out[k] & ready_in[k]`.
- **Occupancy:** per-channel occupancy count of `$clog2(DEPTH)+1` bits.
  - +1 on push only, −1 on pop only, unchanged on both or neither.
- **Pointers:** read/write pointers of `$clog2(DEPTH)` bits wrap naturally modulo `DEPTH`.
- **Full:** occupancy == `DEPTH`. **Empty:** occupancy == 0.
- **Drop:** `req_in[k]` while full and no pop.
  - Data is discarded; FIFO contents are unchanged.
  - `ovf_flag[k]` is set and `ovf_cnt[k]` is incremented unless saturated.
- **Counter precedence:** `ovf_clr` takes priority over a drop in the same cycle; the result is flag=0, cnt=0.
- **Output:** `valid_out[k]` = occupancy ≠ 0, registered. `data_out[k]` = mem[rd_ptr], first-word-fall-through. The value must be stable while `valid_out` is high and `ready_in` is low.
- **Endpoint handshake:**
  - An endpoint may hold `ready_in` high continuously.
  - `valid_out` never depends combinationally on `ready_in`.
- **Reset:**
  - Outputs: `valid_out=0`, `data_out=0`, `ovf_flag=0`, `ovf_cnt=0`.
  - State: pointers and occupancy are 0.
  - Memory contents need no reset.
  - A mid-operation reset flushes all buffered data; `req_in` during reset is ignored.

## Timing
- **Write-to-valid latency:** a push at edge N gives `valid_out` high after edge N+1 when the FIFO was empty. There is no same-cycle bypass.
- **Throughput:** one push and one pop per channel per cycle sustained.
  - A full FIFO with continuous `ready_in` accepts back-to-back `req_in` with no drops.
- **Pop timing:** after a pop at edge N, the next entry appears on `data_out` after edge N. `valid_out` drops after edge N if that pop emptied the FIFO and no push occurred.
- **Overflow timing:** `ovf_flag` and `ovf_cnt` update at the edge following the dropped `req_in`.

## Structure
- **Shared package `comm_pkg`:** default `nOUT`/`wD` constants (shared with the commutator) and the `data_t` typedef `logic [wD-1:0]`.
- **Sub-module `comm_chan_fifo`:** single-channel FIFO (`wD`, `DEPTH`, `wCNT`) with push/pop logic, occupancy and overflow counter.
  - The top level is a generate loop of `nOUT` instances plus bus slicing.

## Test plan
- **Single write:** reset, then `req_in[3]=1` for one cycle with data `0x0ABCDEF` → `valid_out[3]=1` two edges later with `data_out[3]=0x0ABCDEF`; all other channels stay idle. `ready_in[3]=1` → valid clears the next cycle.
- **Fill and drop:** `ready_in=0`, 10 consecutive writes of 1..10 to channel 0 with `DEPTH=8` → 8 stored, `ovf_flag[0]=1`, `ovf_cnt[0]=2`. Then raise `ready_in` → pops 1..8 in order, then `valid_out[0]=0`.
- **Full with simultaneous pop:** FIFO full, push 9 and pop in the same cycle → no drop, occupancy stays 8, order preserved 2..9.
- **All channels + backpressure:** all 13 channels written every cycle for 100 cycles while `ready_in` toggles randomly → scoreboard per-channel order; drop count per channel equals model.
- **Saturation and clear:** 300 drops on channel 12 with `wCNT=8` → `ovf_cnt[12]=255`. `ovf_clr` in the same cycle as a drop → flag and count read 0.
- **Mid-operation reset:** reset asserted while channels hold data and `req_in` is active → next cycle all `valid_out=0` and `data_out=0`. Writes after reset deassertion are delivered with normal latency.
